uart_tx_lab: RTL and testbench
==============================

UART_TX_LAB -- requirements
Module: uart_tx_lab

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts one even-parity bit after the data bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  byte on tx_data is offered.
REQ-007 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL use exactly one clock (clk) with synchronous, active-high reset (rst); there are no other clock or reset inputs.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-012 SHALL assert tx_ready only in IDLE and not while rst is high.
REQ-013 SHALL accept a byte on the rising edge where tx_valid=1 and tx_ready=1; tx_data is latched into an internal shift register at that edge.
REQ-014 SHALL ignore tx_data and tx_valid changes at all other times; the frame uses only the latched byte.
REQ-015 SHALL move IDLE->START at acceptance; tx drives 0 starting in the cycle after the accepting edge (latency 1 cycle).
REQ-016 SHALL hold each bit (start, each data bit, parity, stop) on tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-017 SHALL send data LSB first, bit 0 through bit 7, tracked by a 3-bit index that advances DATA->next bit at the end of each bit period.
REQ-018 SHALL send parity = XOR of the 8 latched bits (even parity) when PARITY_EN=1.
REQ-019 SHALL send exactly one stop bit (tx=1) and then enter IDLE.
REQ-020 SHALL keep the total frame length at 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the first low cycle of tx.
REQ-021 SHALL assert busy in every state except IDLE; busy = ~tx_ready outside reset.
REQ-022 SHALL re-assert tx_ready in the first cycle after the stop bit completes; if tx_valid is held high, the next start bit begins one cycle later with no idle-high gap beyond that cycle.
REQ-023 SHALL drive tx=1 in IDLE and never glitch low outside START/DATA/PARITY.
REQ-024 SHALL size the bit-period counter to $clog2(CLKS_PER_BIT) bits; the counter never exceeds CLKS_PER_BIT-1.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, enter IDLE, clear the counter, bit index and shift register, and drive tx=1, busy=0 from the next cycle.
REQ-026 SHALL hold tx_ready=0 while rst=1 and assert tx_ready=1 in the first cycle after rst falls.
REQ-027 SHALL abort any frame in progress when rst rises mid-frame; the partial frame is not resumed and no byte is retained.

Verification
REQ-028 SHALL verify single byte: CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; busy high for 40 cycles; tx_ready back high afterwards.
REQ-029 SHALL verify parity: PARITY_EN=1, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
REQ-030 SHALL verify back-to-back: tx_valid held high with 0x55 then 0xFF -> second start bit begins 1 cycle after the first stop bit ends; both bytes are received intact by a reference receiver.
REQ-031 SHALL verify data stability: change tx_data from 0x3C to 0xC3 mid-frame -> transmitted byte remains 0x3C.
REQ-032 SHALL verify reset mid-frame: assert rst during data bit 3 for one cycle -> tx=1 and busy=0 from the next cycle; tx_ready=1 in the cycle after rst falls; a new byte 0x81 then transmits correctly.
REQ-033 SHALL verify minimum period: CLKS_PER_BIT=2, send 0x00 -> start bit plus 8 zero bits give 18 low cycles, then 2 high cycles.

Source files
------------

// File: rtl/uart_tx_lab.sv
// rtl/uart_tx_lab.sv - UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit
module uart_tx_lab #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             par, par_n;
  logic             tx_n;
  logic             bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_n;
    end
  end

  assign bit_end = (cnt == LAST_CNT);

  always_comb begin
    state_n   = state;
    cnt_n     = bit_end ? '0 : cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    par_n     = par;
    tx_n      = 1'b1;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid) begin
          state_n   = START;
          shift_n   = tx_data;
          par_n     = ^tx_data;
          bit_idx_n = 3'd0;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // tx is registered from the next state so the line never glitches
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign tx_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_lab.sv
// tb/tb_uart_tx_lab.sv - self-checking bench for uart_tx_lab across three parameter sets
module tb_uart_tx_lab;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] valid_v;
  logic [7:0] data_v [3];
  wire  [2:0] ready_v;
  wire  [2:0] tx_v;
  wire  [2:0] busy_v;

  int checks = 0;
  int errors = 0;
  bit rx_en  = 1'b1;
  logic [7:0] rx_q [$];

  uart_tx_lab #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_p4 (
    .clk(clk), .rst(rst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
  );

  uart_tx_lab #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_p4_par (
    .clk(clk), .rst(rst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
  );

  uart_tx_lab #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u_p2 (
    .clk(clk), .rst(rst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_pop();
    if (rx_q.size() == 0) return 8'bx;
    return rx_q.pop_front();
  endfunction

  // Reference waveform: the frame as a list of line levels, each held cpb cycles
  task automatic send_frame(input int k, input logic [7:0] b, input int cpb, input bit pe,
                            input bit hold, input logic [7:0] alt);
    logic exp_q [$];
    int n;
    n = 0;
    while (ready_v[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, ready_v[k]}, 32'd1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (pe) exp_q.push_back(^b);
    exp_q.push_back(1'b1);
    data_v[k]  = b;
    valid_v[k] = 1'b1;
    @(negedge clk);
    valid_v[k] = hold;
    data_v[k]  = alt;
    foreach (exp_q[i]) begin
      for (int c = 0; c < cpb; c++) begin
        chk("tx_bit", {31'd0, tx_v[k]}, {31'd0, exp_q[i]});
        chk("busy_in_frame", {31'd0, busy_v[k]}, 32'd1);
        if (c == cpb / 2) data_v[k] = ~data_v[k];
        @(negedge clk);
      end
    end
    chk("tx_idle_after", {31'd0, tx_v[k]}, 32'd1);
    chk("ready_after", {31'd0, ready_v[k]}, 32'd1);
    chk("busy_after", {31'd0, busy_v[k]}, 32'd0);
    if (hold) data_v[k] = alt;
  endtask

  // Mid-bit sampling receiver on the CLKS_PER_BIT=4, no-parity instance
  initial begin : rx_model
    logic [7:0] rb;
    logic       sb;
    forever begin
      @(negedge clk);
      if (rx_en && tx_v[0] === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          rb[i] = tx_v[0];
        end
        repeat (4) @(negedge clk);
        sb = tx_v[0];
        if (rx_en) begin
          chk("rx_stop_bit", {31'd0, sb}, 32'd1);
          rx_q.push_back(rb);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] b;
    int n;
    int m;
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_tx", {31'd0, tx_v[k]}, 32'd1);
      chk("reset_busy", {31'd0, busy_v[k]}, 32'd0);
      chk("reset_ready", {31'd0, ready_v[k]}, 32'd0);
    end
    rst_v = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ready_after_reset", {31'd0, ready_v[k]}, 32'd1);

    // single byte 0xA5
    rx_q.delete();
    send_frame(0, 8'hA5, 4, 1'b0, 1'b0, 8'h00);
    chk("rx_a5", {24'd0, rx_pop()}, 32'hA5);

    // back-to-back with tx_valid held high
    send_frame(0, 8'h55, 4, 1'b0, 1'b1, 8'hFF);
    send_frame(0, 8'hFF, 4, 1'b0, 1'b0, 8'h00);
    chk("rx_b2b_first", {24'd0, rx_pop()}, 32'h55);
    chk("rx_b2b_second", {24'd0, rx_pop()}, 32'hFF);

    // tx_data changes mid-frame
    send_frame(0, 8'h3C, 4, 1'b0, 1'b0, 8'hC3);
    chk("rx_stable_3c", {24'd0, rx_pop()}, 32'h3C);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(0, b, 4, 1'b0, 1'b0, 8'($urandom));
      chk("rx_random", {24'd0, rx_pop()}, {24'd0, b});
    end
    chk("rx_queue_empty", rx_q.size(), 32'd0);

    // parity
    send_frame(1, 8'h07, 4, 1'b1, 1'b0, 8'h00);
    send_frame(1, 8'h03, 4, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(1, 8'($urandom), 4, 1'b1, 1'b0, 8'($urandom));
    end

    // minimum bit period: 0x00 gives 18 low cycles then 2 high
    data_v[2]  = 8'h00;
    valid_v[2] = 1'b1;
    @(negedge clk);
    valid_v[2] = 1'b0;
    n = 0;
    while (tx_v[2] === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("min_low_cycles", n, 32'd18);
    m = 0;
    while (tx_v[2] === 1'b1 && busy_v[2] === 1'b1 && m < 100) begin
      m++;
      @(negedge clk);
    end
    chk("min_stop_cycles", m, 32'd2);
    chk("min_ready_after", {31'd0, ready_v[2]}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(2, 8'($urandom), 2, 1'b0, 1'b0, 8'($urandom));
    end

    // reset during data bit 3 of 0x5A
    rx_en      = 1'b0;
    data_v[0]  = 8'h5A;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_frame_bit3", {31'd0, tx_v[0]}, 32'd1);
    chk("mid_frame_busy", {31'd0, busy_v[0]}, 32'd1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("abort_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("abort_ready_in_rst", {31'd0, ready_v[0]}, 32'd0);
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, ready_v[0]}, 32'd1);
    chk("abort_tx_idle", {31'd0, tx_v[0]}, 32'd1);
    chk("abort_busy_idle", {31'd0, busy_v[0]}, 32'd0);
    send_frame(0, 8'h81, 4, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
